// File: rtl/stepper_phase_driver.sv
// Stepper motor phase sequencer: accepts move commands, steps the coil pattern on step_tick rising edges.
// Optional macro HALF_STEP_EN selects the 8-entry half-step sequence instead of the 4-entry full-step one.
module stepper_phase_driver (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        step_tick,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_dir,
  input  logic [15:0] cmd_steps,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [3:0]  coil,
  output logic [15:0] position
);

`ifdef HALF_STEP_EN
  localparam int unsigned PW = 3;
`else
  localparam int unsigned PW = 2;
`endif
  localparam logic [PW-1:0] PH_ONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state;
  logic [PW-1:0]  phase;
  logic [PW-1:0]  next_phase;
  logic [15:0]    remaining;
  logic           dir;
  logic           step_prev;
  logic           step_edge;

  function automatic logic [3:0] coil_of(input logic [PW-1:0] idx);
    logic [3:0] pat;
    pat = 4'b0000;
`ifdef HALF_STEP_EN
    case (idx)
      3'd0: pat = 4'b0001;
      3'd1: pat = 4'b0011;
      3'd2: pat = 4'b0010;
      3'd3: pat = 4'b0110;
      3'd4: pat = 4'b0100;
      3'd5: pat = 4'b1100;
      3'd6: pat = 4'b1000;
      3'd7: pat = 4'b1001;
      default: pat = 4'b0000;
    endcase
`else
    case (idx)
      2'd0: pat = 4'b0011;
      2'd1: pat = 4'b0110;
      2'd2: pat = 4'b1100;
      2'd3: pat = 4'b1001;
      default: pat = 4'b0000;
    endcase
`endif
    return pat;
  endfunction

  always_comb begin
    step_edge  = step_tick && !step_prev;
    next_phase = dir ? (phase + PH_ONE) : (phase - PH_ONE);
  end

  always_ff @(posedge clock_in) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= '0;
      coil      <= coil_of('0);
      position  <= '0;
      remaining <= '0;
      dir       <= 1'b0;
      step_prev <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b1;
    end else begin
      // History tracks step_tick in every state so a level held across accept is not seen as an edge.
      step_prev <= step_tick;
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (cmd_valid && cmd_ready) begin
            dir       <= cmd_dir;
            remaining <= cmd_steps;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (cmd_steps != 16'd0) begin
              state <= RUN;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort) begin
            state <= DONE;
            done  <= 1'b1;
          end else if (step_edge) begin
            phase     <= next_phase;
            coil      <= coil_of(next_phase);
            position  <= dir ? (position + 16'd1) : (position - 16'd1);
            remaining <= remaining - 16'd1;
            if (remaining == 16'd1) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        DONE: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stepper_phase_driver.sv
// Self-checking bench for stepper_phase_driver; define HALF_STEP_EN for both files to check the half-step build.
module tb_stepper_phase_driver;

  logic        clock_in;
  logic        reset;
  logic        step_tick;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [15:0] cmd_steps;
  logic        abort;
  logic        busy;
  logic        done;
  logic [3:0]  coil;
  logic [15:0] position;

  stepper_phase_driver dut (
    .clock_in (clock_in),
    .reset    (reset),
    .step_tick(step_tick),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_dir  (cmd_dir),
    .cmd_steps(cmd_steps),
    .abort    (abort),
    .busy     (busy),
    .done     (done),
    .coil     (coil),
    .position (position)
  );

  initial clock_in = 1'b0;
  always #5 clock_in = ~clock_in;

  int compared = 0;
  int mismatched = 0;
  int done_count = 0;

  // Reference model: phase index and position as plain integers.
  int seq_len;
  logic [3:0] seq_tab [8];
  int m_phase;
  int m_pos;

  always @(negedge clock_in) if (done === 1'b1) done_count++;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running required finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock_in);
    #1;
  endtask

  task automatic send_cmd(input logic d, input logic [15:0] n);
    cmd_valid = 1'b1;
    cmd_dir   = d;
    cmd_steps = n;
    tick();
    cmd_valid = 1'b0;
    cmd_dir   = 1'($urandom);
    cmd_steps = 16'($urandom);
  endtask

  task automatic pulse(input int hi, input int lo);
    step_tick = 1'b1;
    repeat (hi) tick();
    step_tick = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic model_step(input logic d);
    if (d) begin
      m_phase = (m_phase + 1) % seq_len;
      m_pos   = (m_pos + 1) % 65536;
    end else begin
      m_phase = (m_phase + seq_len - 1) % seq_len;
      m_pos   = (m_pos + 65535) % 65536;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    m_phase = 0;
    m_pos   = 0;
  endtask

  task automatic test_reset();
    int d0;
    d0 = done_count;
    do_reset();
    compared++; if (coil !== seq_tab[0]) begin mismatched++; $display("FAIL reset_coil: got %b required %b", coil, seq_tab[0]); end
    compared++; if (position !== 16'd0) begin mismatched++; $display("FAIL reset_position: got %h required 0000", position); end
    compared++; if ({busy, done, cmd_ready} !== 3'b001) begin mismatched++; $display("FAIL reset_flags: got busy/done/ready %b required 001", {busy, done, cmd_ready}); end
    // abort and edges in IDLE must do nothing
    abort = 1'b1;
    pulse(1, 1);
    abort = 1'b0;
    compared++; if (coil !== seq_tab[0] || position !== 16'd0 || done_count != d0) begin mismatched++; $display("FAIL idle_ignore: got coil %b pos %h dones %0d required %b 0000 0", coil, position, done_count - d0, seq_tab[0]); end
  endtask

  task automatic test_forward();
    int d0;
    do_reset();
    d0 = done_count;
    send_cmd(1'b1, 16'd3);
    compared++; if ({busy, cmd_ready} !== 2'b10) begin mismatched++; $display("FAIL fwd_busy: got busy/ready %b required 10", {busy, cmd_ready}); end
    for (int i = 0; i < 3; i++) begin
      pulse(1, 1);
      model_step(1'b1);
      compared++; if (coil !== seq_tab[m_phase]) begin mismatched++; $display("FAIL fwd_coil%0d: got %b required %b", i, coil, seq_tab[m_phase]); end
    end
    tick();
    compared++; if (position !== 16'(m_pos)) begin mismatched++; $display("FAIL fwd_position: got %h required %h", position, 16'(m_pos)); end
    compared++; if (done_count - d0 != 1) begin mismatched++; $display("FAIL fwd_done_count: got %0d required 1", done_count - d0); end
    compared++; if ({busy, cmd_ready} !== 2'b01) begin mismatched++; $display("FAIL fwd_ready: got busy/ready %b required 01", {busy, cmd_ready}); end
  endtask

  task automatic test_reverse_wrap();
    do_reset();
    send_cmd(1'b0, 16'd2);
    for (int i = 0; i < 2; i++) begin
      pulse(2, 1);
      model_step(1'b0);
      compared++; if (coil !== seq_tab[m_phase]) begin mismatched++; $display("FAIL rev_coil%0d: got %b required %b", i, coil, seq_tab[m_phase]); end
    end
    tick();
    compared++; if (position !== 16'hFFFE) begin mismatched++; $display("FAIL rev_position: got %h required fffe", position); end
  endtask

  task automatic test_zero_steps();
    int d0;
    logic seen;
    logic [3:0] c0;
    logic [15:0] p0;
    d0 = done_count;
    c0 = coil;
    p0 = position;
    step_tick = 1'b0;
    tick();
    step_tick = 1'b1;
    send_cmd(1'b1, 16'd0);
    seen = done;
    tick();
    seen = seen | done;
    step_tick = 1'b0;
    tick();
    step_tick = 1'b1;
    tick();
    step_tick = 1'b0;
    tick();
    compared++; if (seen !== 1'b1) begin mismatched++; $display("FAIL zero_done_timing: got %b required 1 within 2 cycles", seen); end
    compared++; if (done_count - d0 != 1) begin mismatched++; $display("FAIL zero_done_count: got %0d required 1", done_count - d0); end
    compared++; if (coil !== c0 || position !== p0) begin mismatched++; $display("FAIL zero_unchanged: got %b %h required %b %h", coil, position, c0, p0); end
    compared++; if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL zero_ready: got %b required 1", cmd_ready); end
  endtask

  task automatic test_abort();
    int d0;
    do_reset();
    d0 = done_count;
    send_cmd(1'b1, 16'd10);
    for (int i = 0; i < 3; i++) begin
      pulse(1, 2);
      model_step(1'b1);
    end
    step_tick = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    compared++; if (done !== 1'b1) begin mismatched++; $display("FAIL abort_done_next: got %b required 1", done); end
    compared++; if (position !== 16'd3 || coil !== seq_tab[m_phase]) begin mismatched++; $display("FAIL abort_position: got %h %b required 0003 %b", position, coil, seq_tab[m_phase]); end
    step_tick = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) pulse(1, 1);
    compared++; if (position !== 16'd3 || coil !== seq_tab[m_phase]) begin mismatched++; $display("FAIL abort_after: got %h %b required 0003 %b", position, coil, seq_tab[m_phase]); end
    compared++; if (done_count - d0 != 1 || busy !== 1'b0) begin mismatched++; $display("FAIL abort_done_count: got %0d busy %b required 1 busy 0", done_count - d0, busy); end
  endtask

  task automatic test_held_high();
    int d0;
    logic [15:0] p0;
    d0 = done_count;
    p0 = 16'(m_pos);
    step_tick = 1'b1;
    repeat (5) tick();
    send_cmd(1'b1, 16'd2);
    repeat (4) tick();
    compared++; if (position !== p0) begin mismatched++; $display("FAIL held_idle_edge: got %h required %h", position, p0); end
    step_tick = 1'b0;
    tick();
    pulse(1000, 1);
    model_step(1'b1);
    compared++; if (position !== 16'(m_pos) || coil !== seq_tab[m_phase]) begin mismatched++; $display("FAIL held_one_step: got %h %b required %h %b", position, coil, 16'(m_pos), seq_tab[m_phase]); end
    compared++; if (busy !== 1'b1) begin mismatched++; $display("FAIL held_still_busy: got %b required 1", busy); end
    pulse(1, 1);
    model_step(1'b1);
    tick();
    compared++; if (position !== 16'(m_pos) || done_count - d0 != 1) begin mismatched++; $display("FAIL held_finish: got %h dones %0d required %h 1", position, done_count - d0, 16'(m_pos)); end
  endtask

  task automatic test_full_cycle();
    do_reset();
    send_cmd(1'b1, 16'd8);
    for (int i = 0; i < 8; i++) begin
      pulse(1, 1);
      model_step(1'b1);
      compared++; if (coil !== seq_tab[m_phase]) begin mismatched++; $display("FAIL cycle_coil%0d: got %b required %b", i, coil, seq_tab[m_phase]); end
    end
    tick();
    compared++; if (coil !== seq_tab[0] || position !== 16'd8) begin mismatched++; $display("FAIL cycle_end: got %b %h required %b 0008", coil, position, seq_tab[0]); end
  endtask

  task automatic test_reset_mid_move();
    int d0;
    do_reset();
    send_cmd(1'b1, 16'd5);
    pulse(1, 1);
    pulse(1, 1);
    d0 = done_count;
    reset = 1'b1;
    cmd_valid = 1'b1;
    cmd_steps = 16'd4;
    abort = 1'b1;
    step_tick = 1'b1;
    tick();
    reset = 1'b0;
    cmd_valid = 1'b0;
    abort = 1'b0;
    step_tick = 1'b0;
    m_phase = 0;
    m_pos = 0;
    compared++; if (coil !== seq_tab[0] || position !== 16'd0) begin mismatched++; $display("FAIL rst_mid_state: got %b %h required %b 0000", coil, position, seq_tab[0]); end
    compared++; if ({busy, done, cmd_ready} !== 3'b001) begin mismatched++; $display("FAIL rst_mid_flags: got %b required 001", {busy, done, cmd_ready}); end
    repeat (3) tick();
    compared++; if (done_count != d0) begin mismatched++; $display("FAIL rst_mid_no_done: got %0d dones required 0", done_count - d0); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int d0;
      int steps;
      int abort_at;
      logic d;
      d = 1'($urandom);
      steps = $urandom_range(0, 12);
      abort_at = ($urandom_range(0, 3) == 0 && steps > 0) ? $urandom_range(1, steps) : 0;
      d0 = done_count;
      compared++; if (cmd_ready !== 1'b1) begin mismatched++; $display("FAIL rnd%0d_ready: got %b required 1", n, cmd_ready); end
      send_cmd(d, 16'(steps));
      for (int i = 1; i <= steps; i++) begin
        if (i == abort_at) begin
          step_tick = 1'b1;
          abort = 1'b1;
          tick();
          abort = 1'b0;
          step_tick = 1'b0;
          tick();
          break;
        end
        pulse($urandom_range(1, 3), $urandom_range(1, 3));
        model_step(d);
      end
      tick();
      tick();
      compared++; if (position !== 16'(m_pos) || coil !== seq_tab[m_phase]) begin mismatched++; $display("FAIL rnd%0d_state: got %h %b required %h %b", n, position, coil, 16'(m_pos), seq_tab[m_phase]); end
      compared++; if (done_count - d0 != 1 || busy !== 1'b0) begin mismatched++; $display("FAIL rnd%0d_done: got %0d busy %b required 1 busy 0", n, done_count - d0, busy); end
    end
  endtask

  initial begin
`ifdef HALF_STEP_EN
    seq_len = 8;
    seq_tab = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0100, 4'b1100, 4'b1000, 4'b1001};
`else
    seq_len = 4;
    seq_tab = '{4'b0011, 4'b0110, 4'b1100, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
`endif
    reset = 1'b1;
    step_tick = 1'b0;
    cmd_valid = 1'b0;
    cmd_dir = 1'b0;
    cmd_steps = '0;
    abort = 1'b0;
    m_phase = 0;
    m_pos = 0;
    test_reset();
    test_forward();
    test_reverse_wrap();
    test_zero_steps();
    test_abort();
    test_held_high();
    test_full_cycle();
    test_reset_mid_move();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
